// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcodes, register field positions,
// per-instruction register-use record and the issue-controller state type.
package rv_pkg;

    localparam logic [6:0] OP       = 7'h33;
    localparam logic [6:0] OP_IMM   = 7'h13;
    localparam logic [6:0] LOAD     = 7'h03;
    localparam logic [6:0] STORE    = 7'h23;
    localparam logic [6:0] BRANCH   = 7'h63;
    localparam logic [6:0] JAL      = 7'h6F;
    localparam logic [6:0] JALR     = 7'h67;
    localparam logic [6:0] LUI      = 7'h37;
    localparam logic [6:0] AUIPC    = 7'h17;
    localparam logic [6:0] MISC_MEM = 7'h0F;
    localparam logic [6:0] SYSTEM   = 7'h73;

    localparam int OPC_LSB = 0;
    localparam int RD_LSB  = 7;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_VALID = 2'd1,
        ST_DRAIN = 2'd2
    } id_state_e;

    typedef struct packed {
        logic uses_rs1;
        logic uses_rs2;
        logic writes_rd;
        logic serialising;
    } reg_use_t;

    function automatic logic [6:0] f_opcode(input logic [31:0] instr);
        return instr[OPC_LSB +: 7];
    endfunction

    function automatic logic [4:0] f_rd(input logic [31:0] instr);
        return instr[RD_LSB +: 5];
    endfunction

    function automatic logic [4:0] f_rs1(input logic [31:0] instr);
        return instr[RS1_LSB +: 5];
    endfunction

    function automatic logic [4:0] f_rs2(input logic [31:0] instr);
        return instr[RS2_LSB +: 5];
    endfunction

endpackage

// File: rtl/reg_use_decode.sv
// Opcode to register-usage classification. Purely combinational so the
// forwarding unit can reuse it unchanged.
module reg_use_decode
    import rv_pkg::*;
(
    input  logic [6:0] opcode_i,
    output reg_use_t   use_o
);

    // Map each opcode to the register fields it reads/writes.
    always_comb begin
        use_o = '0;
        unique case (opcode_i)
            OP:       use_o = '{uses_rs1: 1'b1, uses_rs2: 1'b1, writes_rd: 1'b1, serialising: 1'b0};
            OP_IMM:   use_o = '{uses_rs1: 1'b1, uses_rs2: 1'b0, writes_rd: 1'b1, serialising: 1'b0};
            LOAD:     use_o = '{uses_rs1: 1'b1, uses_rs2: 1'b0, writes_rd: 1'b1, serialising: 1'b0};
            STORE:    use_o = '{uses_rs1: 1'b1, uses_rs2: 1'b1, writes_rd: 1'b0, serialising: 1'b0};
            BRANCH:   use_o = '{uses_rs1: 1'b1, uses_rs2: 1'b1, writes_rd: 1'b0, serialising: 1'b0};
            JAL:      use_o = '{uses_rs1: 1'b0, uses_rs2: 1'b0, writes_rd: 1'b1, serialising: 1'b0};
            JALR:     use_o = '{uses_rs1: 1'b1, uses_rs2: 1'b0, writes_rd: 1'b1, serialising: 1'b0};
            LUI:      use_o = '{uses_rs1: 1'b0, uses_rs2: 1'b0, writes_rd: 1'b1, serialising: 1'b0};
            AUIPC:    use_o = '{uses_rs1: 1'b0, uses_rs2: 1'b0, writes_rd: 1'b1, serialising: 1'b0};
            MISC_MEM: use_o = '{uses_rs1: 1'b0, uses_rs2: 1'b0, writes_rd: 1'b0, serialising: 1'b1};
            SYSTEM:   use_o = '{uses_rs1: 1'b0, uses_rs2: 1'b0, writes_rd: 1'b0, serialising: 1'b1};
            default:  use_o = '0;
        endcase
    end

endmodule

// File: rtl/id_issue_ctrl.sv
// Decode-stage issue controller: one-instruction slot in front of EX with a
// register scoreboard that blocks RAW/WAW hazards, caps outstanding writers,
// drains before FENCE/SYSTEM, honours flush and counts stall cycles.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_EMPTY | no instruction held
// ST_VALID | ordinary instruction held, issues when hazard-free
// ST_DRAIN | serialising instruction held, issues once scoreboard is clear
module id_issue_ctrl
    import rv_pkg::*;
#(
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_valid,
    input  logic [31:0]      if_instr,
    output logic             if_ready,
    input  logic             ex_ready,
    output logic             id_issue,
    output logic [31:0]      id_instr,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic             flush,
    output logic [31:0]      busy_vec,
    output logic [3:0]       inflight,
    output logic [CNT_W-1:0] stall_cnt
);

    id_state_e        state_q, state_d;
    logic [31:0]      instr_q, instr_d;
    reg_use_t         use_q, use_d;
    logic [31:0]      busy_q, busy_d;
    logic [3:0]       inflight_q, inflight_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    reg_use_t    in_use;
    logic [4:0]  slot_rd, slot_rs1, slot_rs2;
    logic [31:0] wb_mask, eff_busy;
    logic        wb_clr, set_en, cap_full, hazard;
    logic        issue_c, ready_c, accept;

    // Incoming instruction is classified at accept time and the result kept
    // alongside the slot, so the hazard path only sees registered decode.
    reg_use_decode u_decode (
        .opcode_i (f_opcode(if_instr)),
        .use_o    (in_use)
    );

    assign slot_rd  = f_rd(instr_q);
    assign slot_rs1 = f_rs1(instr_q);
    assign slot_rs2 = f_rs2(instr_q);

    // Same-cycle writeback bypass and hazard evaluation on the slot.
    always_comb begin
        wb_mask  = wb_valid ? (32'd1 << wb_rd) : 32'd0;
        eff_busy = busy_q & ~wb_mask;
        wb_clr   = wb_valid && (wb_rd != 5'd0) && busy_q[wb_rd];
        cap_full = (inflight_q == 4'(MAX_INFLIGHT)) && !wb_clr;
        hazard   = (use_q.uses_rs1  && eff_busy[slot_rs1])
                || (use_q.uses_rs2  && eff_busy[slot_rs2])
                || (use_q.writes_rd && eff_busy[slot_rd])
                || (use_q.writes_rd && cap_full);
        issue_c  = reset && !flush && ex_ready
                && (((state_q == ST_VALID) && !hazard)
                 || ((state_q == ST_DRAIN) && (eff_busy == 32'd0)));
        ready_c  = reset && !flush && ((state_q == ST_EMPTY) || issue_c);
        accept   = if_valid && ready_c;
        set_en   = issue_c && use_q.writes_rd && (slot_rd != 5'd0);
    end

    // Next-state computation for slot, scoreboard and stall counter.
    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        use_d      = use_q;
        busy_d     = busy_q;
        inflight_d = inflight_q;
        stall_d    = stall_q;

        if (flush) begin
            state_d = ST_EMPTY;
        end else if (accept) begin
            state_d = in_use.serialising ? ST_DRAIN : ST_VALID;
            instr_d = if_instr;
            use_d   = in_use;
        end else if (issue_c) begin
            state_d = ST_EMPTY;
        end

        // Clear first so that an issue-set of the same register wins.
        if (wb_clr) begin
            busy_d[wb_rd] = 1'b0;
        end
        if (set_en) begin
            busy_d[slot_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;

        unique case ({set_en, wb_clr})
            2'b10:   inflight_d = inflight_q + 4'd1;
            2'b01:   inflight_d = inflight_q - 4'd1;
            default: inflight_d = inflight_q;
        endcase

        if ((state_q != ST_EMPTY) && !issue_c && !flush
                && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_EMPTY;
            instr_q    <= 32'd0;
            use_q      <= '0;
            busy_q     <= 32'd0;
            inflight_q <= 4'd0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            use_q      <= use_d;
            busy_q     <= busy_d;
            inflight_q <= inflight_d;
            stall_q    <= stall_d;
        end
    end

    assign id_issue  = issue_c;
    assign if_ready  = ready_c;
    assign id_instr  = instr_q;
    assign busy_vec  = busy_q;
    assign inflight  = inflight_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Bench for id_issue_ctrl: directed vector table, hand-written corner
// sequences and a randomized run, all compared against a register-set model.
module tb_id_issue_ctrl;

    localparam int MAXI      = 4;
    localparam int TB_CNT_W  = 5;
    localparam int STALL_MAX = (1 << TB_CNT_W) - 1;

    logic                clk;
    logic                reset, if_valid, ex_ready, wb_valid, flush;
    logic [31:0]         if_instr;
    logic [4:0]          wb_rd;
    logic                if_ready, id_issue;
    logic [31:0]         id_instr, busy_vec;
    logic [3:0]          inflight;
    logic [TB_CNT_W-1:0] stall_cnt;

    id_issue_ctrl #(.MAX_INFLIGHT(MAXI), .CNT_W(TB_CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_valid  (if_valid),
        .if_instr  (if_instr),
        .if_ready  (if_ready),
        .ex_ready  (ex_ready),
        .id_issue  (id_issue),
        .id_instr  (id_instr),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .flush     (flush),
        .busy_vec  (busy_vec),
        .inflight  (inflight),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // ---------------- reference model ----------------
    bit          m_busy[32];
    int          m_inflight, m_stall;
    bit          m_valid, m_serial;
    logic [31:0] m_instr;
    bit          m_iss, m_rdy;

    function automatic logic [31:0] enc(input logic [6:0] op, input int rd, input int rs1, input int rs2);
        return {7'b0, 5'(rs2), 5'(rs1), 3'b0, 5'(rd), op};
    endfunction

    function automatic bit reads1(input logic [31:0] i);
        return i[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
    endfunction
    function automatic bit reads2(input logic [31:0] i);
        return i[6:0] inside {7'h33, 7'h23, 7'h63};
    endfunction
    function automatic bit writes(input logic [31:0] i);
        return i[6:0] inside {7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67};
    endfunction
    function automatic bit serial(input logic [31:0] i);
        return i[6:0] inside {7'h0F, 7'h73};
    endfunction
    function automatic int fld(input logic [31:0] i, input int lsb);
        return int'((i >> lsb) & 32'h1F);
    endfunction

    function automatic bit eff(input int r);
        return m_busy[r] && !(wb_valid && (int'(wb_rd) == r));
    endfunction

    function automatic logic [31:0] pack_busy();
        logic [31:0] v;
        v = 32'd0;
        for (int r = 0; r < 32; r++) if (m_busy[r]) v = v | (32'd1 << r);
        return v;
    endfunction

    task automatic model_comb();
        bit any_busy, retiring, hz;
        any_busy = 0;
        for (int r = 0; r < 32; r++) if (eff(r)) any_busy = 1;
        retiring = wb_valid && (wb_rd != 5'd0) && m_busy[wb_rd];
        hz = (reads1(m_instr) && eff(fld(m_instr, 15)))
          || (reads2(m_instr) && eff(fld(m_instr, 20)))
          || (writes(m_instr) && eff(fld(m_instr, 7)))
          || (writes(m_instr) && m_inflight >= MAXI && !retiring);
        m_iss = 0;
        if (reset && !flush && ex_ready && m_valid)
            m_iss = m_serial ? !any_busy : !hz;
        m_rdy = reset && !flush && (!m_valid || m_iss);
    endtask

    task automatic model_tick();
        bit clr, st;
        int rd;
        model_comb();
        if (!reset) begin
            for (int r = 0; r < 32; r++) m_busy[r] = 0;
            m_inflight = 0; m_stall = 0; m_valid = 0; m_serial = 0; m_instr = 32'd0;
        end else begin
            if (m_valid && !m_iss && !flush && m_stall < STALL_MAX) m_stall++;
            rd  = fld(m_instr, 7);
            clr = wb_valid && (wb_rd != 5'd0) && m_busy[wb_rd];
            st  = m_iss && writes(m_instr) && rd != 0;
            if (clr) begin m_busy[wb_rd] = 0; m_inflight--; end
            if (st)  begin m_busy[rd] = 1;    m_inflight++; end
            if (flush) m_valid = 0;
            else if (if_valid && m_rdy) begin
                m_valid = 1; m_instr = if_instr; m_serial = serial(if_instr);
            end else if (m_iss) m_valid = 0;
        end
    endtask

    // ---------------- checking / driving ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic set_in(input logic rst, input logic iv, input logic [31:0] ins, input logic exr,
                          input logic wbv, input int wbr, input logic fl);
        @(negedge clk);
        reset = rst; if_valid = iv; if_instr = ins; ex_ready = exr;
        wb_valid = wbv; wb_rd = 5'(wbr); flush = fl;
        #1;
    endtask

    task automatic check_model();
        model_comb();
        chk("issue",     32'(id_issue),   32'(m_iss));
        chk("if_ready",  32'(if_ready),   32'(m_rdy));
        chk("id_instr",  id_instr,        m_instr);
        chk("busy_vec",  busy_vec,        pack_busy());
        chk("inflight",  32'(inflight),   32'(m_inflight));
        chk("stall_cnt", 32'(stall_cnt),  32'(m_stall));
    endtask

    task automatic tick();
        @(posedge clk);
        model_tick();
    endtask

    task automatic cyc(input logic iv, input logic [31:0] ins, input logic wbv, input int wbr);
        set_in(1'b1, iv, ins, 1'b1, wbv, wbr, 1'b0);
        check_model();
        tick();
    endtask

    task automatic retire_all();
        repeat (3) cyc(1'b0, 32'd0, 1'b0, 0);
        for (int r = 1; r < 32; r++) if (m_busy[r]) cyc(1'b0, 32'd0, 1'b1, r);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        iv;
        logic [31:0] ins;
        logic        wbv;
        int          wbr;
        logic        e_iss, e_rdy;
        logic [31:0] e_busy;
        int          e_inf, e_stall;
    } vec_t;

    function automatic vec_t mk(input logic iv, input logic [31:0] ins, input logic wbv, input int wbr,
                                input logic ei, input logic er, input logic [31:0] eb, input int ef, input int es);
        vec_t v;
        v.iv = iv; v.ins = ins; v.wbv = wbv; v.wbr = wbr;
        v.e_iss = ei; v.e_rdy = er; v.e_busy = eb; v.e_inf = ef; v.e_stall = es;
        return v;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] op;
        case ($urandom_range(0, 11))
            0: op = 7'h33;  1: op = 7'h13;  2: op = 7'h03;  3: op = 7'h23;
            4: op = 7'h63;  5: op = 7'h6F;  6: op = 7'h67;  7: op = 7'h37;
            8: op = 7'h17;  9: op = 7'h0F; 10: op = 7'h73; default: op = 7'h7F;
        endcase
        return enc(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
    endfunction

    vec_t tbl[15];

    initial begin
        logic [31:0] add655, addi1, addi2, addi5;
        int q[$];
        logic rst_r, iv_r, exr_r, wbv_r, fl_r;
        int wbr_r;

        addi1  = enc(7'h13, 1, 0, 1);
        addi2  = enc(7'h13, 2, 0, 2);
        addi5  = enc(7'h13, 5, 0, 5);
        add655 = enc(7'h33, 6, 5, 5);

        tbl[0]  = mk(1, addi1,  0, 0, 0, 1, 32'h00, 0, 0);
        tbl[1]  = mk(1, addi2,  0, 0, 1, 1, 32'h00, 0, 0);
        tbl[2]  = mk(1, addi5,  0, 0, 1, 1, 32'h02, 1, 0);
        tbl[3]  = mk(1, add655, 0, 0, 1, 1, 32'h06, 2, 0);
        tbl[4]  = mk(0, 32'd0,  0, 0, 0, 0, 32'h26, 3, 0);
        tbl[5]  = mk(0, 32'd0,  0, 0, 0, 0, 32'h26, 3, 1);
        tbl[6]  = mk(0, 32'd0,  0, 0, 0, 0, 32'h26, 3, 2);
        tbl[7]  = mk(0, 32'd0,  1, 5, 1, 1, 32'h26, 3, 3);
        tbl[8]  = mk(0, 32'd0,  1, 1, 0, 1, 32'h46, 3, 3);
        tbl[9]  = mk(0, 32'd0,  1, 2, 0, 1, 32'h44, 2, 3);
        tbl[10] = mk(0, 32'd0,  0, 0, 0, 1, 32'h40, 1, 3);
        tbl[11] = mk(0, 32'd0,  1, 0, 0, 1, 32'h40, 1, 3);
        tbl[12] = mk(0, 32'd0,  1, 3, 0, 1, 32'h40, 1, 3);
        tbl[13] = mk(0, 32'd0,  1, 6, 0, 1, 32'h40, 1, 3);
        tbl[14] = mk(0, 32'd0,  0, 0, 0, 1, 32'h00, 0, 3);

        reset = 0; if_valid = 0; if_instr = 0; ex_ready = 0; wb_valid = 0; wb_rd = 0; flush = 0;

        // Initial reset; DUT state is unknown before the first edge.
        set_in(1'b0, 1'b1, addi1, 1'b1, 1'b0, 0, 1'b0);
        tick();
        set_in(1'b0, 1'b1, addi1, 1'b1, 1'b1, 3, 1'b0);
        chk("rst_issue", 32'(id_issue), 32'd0);
        chk("rst_ready", 32'(if_ready), 32'd0);
        chk("rst_busy",  busy_vec, 32'd0);
        chk("rst_instr", id_instr, 32'd0);
        check_model();
        tick();

        // Back-to-back independent ops, then RAW stall released by a bypassed writeback.
        for (int i = 0; i < 15; i++) begin
            set_in(1'b1, tbl[i].iv, tbl[i].ins, 1'b1, tbl[i].wbv, tbl[i].wbr, 1'b0);
            chk($sformatf("tbl%0d_issue", i),    32'(id_issue),  32'(tbl[i].e_iss));
            chk($sformatf("tbl%0d_ready", i),    32'(if_ready),  32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_busy", i),     busy_vec,       tbl[i].e_busy);
            chk($sformatf("tbl%0d_inflight", i), 32'(inflight),  32'(tbl[i].e_inf));
            chk($sformatf("tbl%0d_stall", i),    32'(stall_cnt), 32'(tbl[i].e_stall));
            check_model();
            tick();
        end

        // WAW / inflight cap: four writers outstanding block a fifth.
        for (int r = 1; r <= 4; r++) cyc(1'b1, enc(7'h13, r, 0, r), 1'b0, 0);
        cyc(1'b1, enc(7'h13, 7, 0, 7), 1'b0, 0);
        for (int k = 0; k < 3; k++) begin
            set_in(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 0, 1'b0);
            chk("cap_hold_issue", 32'(id_issue), 32'd0);
            chk("cap_inflight",   32'(inflight), 32'd4);
            check_model();
            tick();
        end
        set_in(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 2, 1'b0);
        chk("cap_release_issue", 32'(id_issue), 32'd1);
        check_model();
        tick();
        set_in(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 0, 1'b0);
        chk("cap_after_inflight", 32'(inflight), 32'd4);
        chk("cap_after_busy",     busy_vec,      32'h9A);
        check_model();
        tick();
        retire_all();

        // FENCE drain waits for x4 and x8.
        cyc(1'b1, enc(7'h13, 4, 0, 0), 1'b0, 0);
        cyc(1'b1, enc(7'h13, 8, 0, 0), 1'b0, 0);
        cyc(1'b1, enc(7'h0F, 0, 0, 0), 1'b0, 0);
        set_in(1'b1, 1'b1, enc(7'h13, 9, 0, 0), 1'b1, 1'b0, 0, 1'b0);
        chk("fence_busy",   busy_vec, 32'h110);
        chk("fence_issue0", 32'(id_issue), 32'd0);
        chk("fence_ready0", 32'(if_ready), 32'd0);
        check_model();
        tick();
        set_in(1'b1, 1'b1, enc(7'h13, 9, 0, 0), 1'b1, 1'b1, 4, 1'b0);
        chk("fence_issue1", 32'(id_issue), 32'd0);
        chk("fence_ready1", 32'(if_ready), 32'd0);
        check_model();
        tick();
        set_in(1'b1, 1'b1, enc(7'h13, 9, 0, 0), 1'b1, 1'b1, 8, 1'b0);
        chk("fence_issue2", 32'(id_issue), 32'd1);
        chk("fence_ready2", 32'(if_ready), 32'd1);
        check_model();
        tick();
        retire_all();

        // Flush while a RAW-stalled add is held.
        cyc(1'b1, addi5, 1'b0, 0);
        cyc(1'b1, add655, 1'b0, 0);
        cyc(1'b0, 32'd0, 1'b0, 0);
        set_in(1'b1, 1'b1, enc(7'h13, 9, 0, 0), 1'b1, 1'b0, 0, 1'b1);
        chk("flush_issue", 32'(id_issue), 32'd0);
        chk("flush_ready", 32'(if_ready), 32'd0);
        check_model();
        tick();
        set_in(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 0, 1'b0);
        chk("flush_busy",   busy_vec, 32'h20);
        chk("flush_empty",  32'(if_ready), 32'd1);
        chk("flush_instr",  id_instr, add655);
        check_model();
        tick();

        // Stall counter saturation.
        cyc(1'b1, add655, 1'b0, 0);
        repeat (40) cyc(1'b0, 32'd0, 1'b0, 0);
        set_in(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 0, 1'b0);
        chk("stall_sat", 32'(stall_cnt), 32'(STALL_MAX));
        check_model();
        tick();
        retire_all();

        // Reset mid-operation with three writers outstanding.
        for (int r = 1; r <= 3; r++) cyc(1'b1, enc(7'h13, r, 0, 0), 1'b0, 0);
        cyc(1'b0, 32'd0, 1'b0, 0);
        set_in(1'b0, 1'b1, addi5, 1'b1, 1'b0, 0, 1'b0);
        chk("mid_rst_issue", 32'(id_issue), 32'd0);
        chk("mid_rst_ready", 32'(if_ready), 32'd0);
        tick();
        set_in(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1, 1'b0);
        chk("post_rst_busy",  busy_vec, 32'd0);
        chk("post_rst_infl",  32'(inflight), 32'd0);
        chk("post_rst_stall", 32'(stall_cnt), 32'd0);
        chk("post_rst_instr", id_instr, 32'd0);
        check_model();
        tick();
        set_in(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 0, 1'b0);
        chk("post_wb_infl", 32'(inflight), 32'd0);
        check_model();
        tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst_r = ($urandom_range(0, 299) != 0);
            iv_r  = ($urandom_range(0, 9) < 7);
            exr_r = ($urandom_range(0, 4) != 0);
            fl_r  = ($urandom_range(0, 15) == 0);
            wbv_r = ($urandom_range(0, 2) != 0);
            q.delete();
            for (int r = 1; r < 32; r++) if (m_busy[r]) q.push_back(r);
            if (q.size() > 0 && $urandom_range(0, 1) == 1) wbr_r = q[$urandom_range(0, q.size() - 1)];
            else wbr_r = $urandom_range(0, 7);
            set_in(rst_r, iv_r, rand_instr(), exr_r, wbv_r, wbr_r, fl_r);
            check_model();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
